// File: rtl/shift_seq_pkg.sv
// Shared types and constants for the multi-cycle sequential shifter.
// Optional feature macro: SHIFT_SEQ_ROTATE_EN (rotate mode), used by the
// files that import this package.
package shift_seq_pkg;

  localparam int WIDTH_DEF = 16;
  localparam int AMT_W_DEF = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  typedef logic [1:0] mode_t;

  localparam mode_t SH_LEFT   = 2'd0;
  localparam mode_t SH_LRIGHT = 2'd1;
  localparam mode_t SH_ARIGHT = 2'd2;
  localparam mode_t SH_ROT    = 2'd3;

  // Collapse the request bits into one mode; rotate takes priority over arith,
  // and arith only matters for right shifts.
  function automatic mode_t mode_of(input logic right, input logic arith, input logic rotate);
    mode_t m;
    if (rotate) begin
      m = SH_ROT;
    end else if (!right) begin
      m = SH_LEFT;
    end else if (arith) begin
      m = SH_ARIGHT;
    end else begin
      m = SH_LRIGHT;
    end
    return m;
  endfunction

endpackage

// File: rtl/shift_step.sv
// Combinational single-position shift/rotate step.
// Optional feature macro: SHIFT_SEQ_ROTATE_EN; without it the rotate input is
// accepted but ignored and no rotate fill path exists.
module shift_step #(
  parameter int WIDTH = 16
) (
  input  logic [WIDTH-1:0] i_word,
  input  logic             i_right,
  input  logic             i_arith,
  input  logic             i_rotate,
  output logic [WIDTH-1:0] o_next,
  output logic             o_out_bit
);

  logic w_fill;

`ifndef SHIFT_SEQ_ROTATE_EN
  logic w_unused_rotate;
  assign w_unused_rotate = i_rotate;
`endif

  // Pick the bit leaving the word and the bit entering at the opposite end.
  always_comb begin
    w_fill    = 1'b0;
    o_out_bit = 1'b0;
    o_next    = i_word;
    if (i_right) begin
      o_out_bit = i_word[0];
      w_fill    = i_arith ? i_word[WIDTH-1] : 1'b0;
`ifdef SHIFT_SEQ_ROTATE_EN
      if (i_rotate) begin
        w_fill = i_word[0];
      end
`endif
      o_next = {w_fill, i_word[WIDTH-1:1]};
    end else begin
      o_out_bit = i_word[WIDTH-1];
`ifdef SHIFT_SEQ_ROTATE_EN
      if (i_rotate) begin
        w_fill = i_word[WIDTH-1];
      end
`endif
      o_next = {i_word[WIDTH-2:0], w_fill};
    end
  end

endmodule

// File: rtl/shift_seq.sv
// Multi-cycle sequential shifter: one single-position step per clock until the
// requested amount is done, with a start/ready/done handshake.
// Optional feature macro: SHIFT_SEQ_ROTATE_EN enables rotate mode; when it is
// undefined the rotate port is still present but treated as 0.
//
// state | meaning
// ------+-----------------------------------------------------------
// IDLE  | ready=1, result held; start loads operand and amount
// RUN   | one step per edge, count decrements; 1->0 edge goes to DONE
// DONE  | done=1 for exactly one cycle, then back to IDLE
module shift_seq
  import shift_seq_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF,
  parameter int AMT_W = AMT_W_DEF
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  output logic             ready,
  input  logic [WIDTH-1:0] in_16,
  input  logic [AMT_W-1:0] amount,
  input  logic             right,
  input  logic             arith,
  input  logic             rotate,
  output logic [WIDTH-1:0] out_16,
  output logic             carry,
  output logic             done
);

  if (AMT_W != $clog2(WIDTH)) begin : g_bad_amt_w
    $error("shift_seq: AMT_W must equal clog2(WIDTH)");
  end

  state_t           r_state;
  state_t           w_next_state;
  logic [WIDTH-1:0] r_out;
  logic             r_carry;
  logic [AMT_W-1:0] r_count;
  logic             r_right;
  mode_t            r_mode;

  logic             w_ready;
  logic             w_done;
  logic             w_accept;
  logic             w_rot_req;
  logic [WIDTH-1:0] w_step_next;
  logic             w_step_bit;

`ifdef SHIFT_SEQ_ROTATE_EN
  assign w_rot_req = rotate;
`else
  logic w_unused_rotate;
  assign w_unused_rotate = rotate;
  assign w_rot_req       = 1'b0;
`endif

  assign w_accept = start & w_ready;

  shift_step #(
    .WIDTH (WIDTH)
  ) u_step (
    .i_word    (r_out),
    .i_right   (r_right),
    .i_arith   (r_mode == SH_ARIGHT),
    .i_rotate  (r_mode == SH_ROT),
    .o_next    (w_step_next),
    .o_out_bit (w_step_bit)
  );

  // Next-state and handshake outputs, decoded from the current state.
  always_comb begin
    w_next_state = r_state;
    w_ready      = 1'b0;
    w_done       = 1'b0;
    case (r_state)
      IDLE: begin
        w_ready = 1'b1;
        if (start) begin
          w_next_state = (amount == '0) ? DONE : RUN;
        end
      end
      RUN: begin
        if (r_count == AMT_W'(1)) begin
          w_next_state = DONE;
        end
      end
      DONE: begin
        w_done       = 1'b1;
        w_next_state = IDLE;
      end
      default: begin
        w_next_state = IDLE;
      end
    endcase
  end

  // State register with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  // Datapath: load on accept, step and count down while running, hold otherwise.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_out   <= '0;
      r_carry <= 1'b0;
      r_count <= '0;
      r_right <= 1'b0;
      r_mode  <= SH_LEFT;
    end else if (w_accept) begin
      r_out   <= in_16;
      r_carry <= 1'b0;
      r_count <= amount;
      r_right <= right;
      r_mode  <= mode_of(right, arith, w_rot_req);
    end else if (r_state == RUN) begin
      r_out   <= w_step_next;
      r_carry <= w_step_bit;
      r_count <= r_count - AMT_W'(1);
    end
  end

  assign ready  = w_ready;
  assign done   = w_done;
  assign out_16 = r_out;
  assign carry  = r_carry;

endmodule

// File: tb/tb_shift_seq.sv
// Randomized + directed bench for shift_seq with a queue-based scoreboard.
// Reference results come from closed-form shift/rotate arithmetic.
module tb_shift_seq;
  localparam int W  = 16;
  localparam int AW = 4;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          start = 1'b0;
  logic          right = 1'b0;
  logic          arith = 1'b0;
  logic          rotate = 1'b0;
  logic [W-1:0]  in_16 = '0;
  logic [AW-1:0] amount = '0;
  logic          ready;
  logic          carry;
  logic          done;
  logic [W-1:0]  out_16;

  shift_seq #(.WIDTH(W), .AMT_W(AW)) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .start  (start),
    .ready  (ready),
    .in_16  (in_16),
    .amount (amount),
    .right  (right),
    .arith  (arith),
    .rotate (rotate),
    .out_16 (out_16),
    .carry  (carry),
    .done   (done)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [W-1:0] out;
    logic         c;
    int           cyc;
  } exp_t;

  exp_t         sb[$];
  int           n_vec = 0;
  int           n_err = 0;
  logic [W-1:0] last_out = '0;
  logic         last_c = 1'b0;
  bit           have_last = 1'b0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
    end
  endtask

  function automatic exp_t model(input logic [W-1:0] din, input int n, input bit r, input bit a, input bit rot);
    exp_t e;
    bit   rot_eff;
`ifdef SHIFT_SEQ_ROTATE_EN
    rot_eff = rot;
`else
    rot_eff = 1'b0;
`endif
    e.cyc = 0;
    if (n == 0) begin
      e.out = din;
      e.c   = 1'b0;
    end else if (rot_eff && !r) begin
      e.out = (din << n) | (din >> (W - n));
      e.c   = e.out[0];
    end else if (rot_eff && r) begin
      e.out = (din >> n) | (din << (W - n));
      e.c   = e.out[W-1];
    end else if (!r) begin
      e.out = din << n;
      e.c   = din[W-n];
    end else if (a) begin
      e.out = $signed(din) >>> n;
      e.c   = din[n-1];
    end else begin
      e.out = din >> n;
      e.c   = din[n-1];
    end
    return e;
  endfunction

  // Monitor: every done pulse must match the oldest outstanding expectation.
  always @(negedge clk) begin : monitor
    exp_t e;
    if (rst_n && done) begin
      chk("ready_low_in_done", {31'b0, ready}, 32'd0);
      if (sb.size() == 0) begin
        n_vec++;
        n_err++;
        $display("FAIL spurious_done: got done=1 at cycle %0d expected no pending op", cyc);
      end else begin
        e = sb.pop_front();
        chk("result_out", {16'b0, out_16}, {16'b0, e.out});
        chk("result_carry", {31'b0, carry}, {31'b0, e.c});
        chk("done_cycle", cyc, e.cyc);
        last_out  = e.out;
        last_c    = e.c;
        have_last = 1'b1;
      end
    end
  end

  // Issue one operation (caller sits at a negedge) and wait for its done pulse.
  task automatic do_op(input logic [W-1:0] din, input int amt, input bit r, input bit a,
                       input bit rot, input bit hold);
    exp_t e;
    bit   seen;
    for (int k = 0; k < 50 && !ready; k++) @(negedge clk);
    if (!ready) begin
      chk("ready_timeout", {31'b0, ready}, 32'd1);
      return;
    end
    if (have_last) begin
      chk("hold_out", {16'b0, out_16}, {16'b0, last_out});
      chk("hold_carry", {31'b0, carry}, {31'b0, last_c});
    end
    in_16  = din;
    amount = AW'(amt);
    right  = r;
    arith  = a;
    rotate = rot;
    start  = 1'b1;
    e      = model(din, amt, r, a, rot);
    e.cyc  = cyc + 1 + amt;
    sb.push_back(e);
    @(negedge clk);
    if (!hold) start = 1'b0;
    in_16  = $urandom;
    amount = AW'($urandom);
    right  = 1'($urandom);
    arith  = 1'($urandom);
    rotate = 1'($urandom);
    seen   = done;
    for (int k = 0; k < 40 && !seen; k++) begin
      @(negedge clk);
      seen = done;
    end
    start = 1'b0;
    if (!seen) chk("done_timeout", 32'd0, 32'd1);
  endtask

  initial begin
    repeat (2) @(negedge clk);
    chk("rst_ready", {31'b0, ready}, 32'd1);
    chk("rst_out", {16'b0, out_16}, 32'd0);
    chk("rst_carry", {31'b0, carry}, 32'd0);
    chk("rst_done", {31'b0, done}, 32'd0);
    rst_n = 1'b1;
    @(negedge clk);

    // Directed cases from the plan.
    do_op(16'h8001, 3, 1'b1, 1'b1, 1'b0, 1'b0);
    do_op(16'h8001, 3, 1'b1, 1'b0, 1'b0, 1'b0);
    do_op(16'h8001, 1, 1'b0, 1'b0, 1'b0, 1'b0);
    do_op(16'h1234, 0, 1'b0, 1'b0, 1'b0, 1'b0);
    do_op(16'hFFFF, 15, 1'b1, 1'b0, 1'b0, 1'b0);
    do_op(16'h8001, 4, 1'b0, 1'b0, 1'b1, 1'b0);
    do_op(16'h8001, 4, 1'b1, 1'b1, 1'b1, 1'b0);

    // Start held through RUN and DONE, then an immediate back-to-back op.
    do_op(16'hA5C3, 5, 1'b0, 1'b0, 1'b0, 1'b1);
    do_op(16'h00F0, 2, 1'b1, 1'b0, 1'b0, 1'b0);
    repeat (3) @(negedge clk);

    // Reset in the middle of RUN.
    in_16  = 16'hBEEF;
    amount = AW'(10);
    right  = 1'b0;
    arith  = 1'b0;
    rotate = 1'b0;
    start  = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    sb.delete();
    have_last = 1'b0;
    chk("midrun_rst_ready", {31'b0, ready}, 32'd1);
    chk("midrun_rst_out", {16'b0, out_16}, 32'd0);
    chk("midrun_rst_carry", {31'b0, carry}, 32'd0);
    chk("midrun_rst_done", {31'b0, done}, 32'd0);
    do_op(16'h8001, 3, 1'b1, 1'b1, 1'b0, 1'b0);

    // Random operations.
    for (int i = 0; i < 40; i++) begin
      do_op(16'($urandom), int'($urandom_range(0, W - 1)), 1'($urandom), 1'($urandom),
            1'($urandom), 1'($urandom_range(0, 3) == 0));
    end

    repeat (4) @(negedge clk);
    chk("scoreboard_empty", sb.size(), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
